sc_io_ports: RTL
================

SC_IO_PORTS -- requirements
Module: sc_io_ports

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_OUT, 2: output port count (1..8).
- NUM_IN, 2: input port count (1..8).
- PORT_W, 32: port width (1..32); reads zero-extend to 32 bits.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- addr, in, 32: byte address from the CPU ALU result.
- wdata, in, 32: store data.
- we, in, 1: store strobe.
- re, in, 1: load strobe.
- io_sel, out, 1: combinational, equals addr[7].
- rdata, out, 32: registered load data.
- rvalid, out, 1: registered; marks rdata valid.
- out_ports, out, NUM_OUT*PORT_W: port k occupies bits [k*PORT_W +: PORT_W].
- in_ports, in, NUM_IN*PORT_W: asynchronous external inputs, same packing as out_ports.
- irq, out, 1: registered interrupt request.

Function
REQ-003 The block SHALL decode an access only when io_sel=1; addr[1:0] is ignored.
REQ-004 The address map SHALL be:
- 0x80+4k: OUT[k], read/write, k<NUM_OUT.
- 0xC0+4k: IN[k], read-only, k<NUM_IN.
- 0xF0: STAT, read / write-1-to-clear, bits [NUM_IN-1:0].
- 0xF4: MASK, read/write, bits [NUM_IN-1:0].
- 0xF8: CYC, read-only, 32-bit.
REQ-005 A write (we=1, mapped writable address) SHALL update the register at the clock edge; out_ports SHALL show the new value from the following cycle.
REQ-006 Writes to read-only or unmapped addresses SHALL be ignored; wdata bits above PORT_W or NUM_IN SHALL be discarded.
REQ-007 Each in_ports lane SHALL pass through a two-flop synchronizer; IN[k] reads return the second stage.
REQ-008 A third register per lane SHALL hold the previous synchronized value; any bit difference between stages SHALL set STAT[k] on the next edge.
REQ-009 STAT bits SHALL be sticky until cleared by writing 1 to that bit.
REQ-010 If a set and a W1C coincide on the same bit in the same cycle, the set SHALL win.
REQ-011 irq SHALL be registered as |(STAT & MASK) evaluated on the updated values; irq therefore asserts on the same edge STAT sets.
REQ-012 Reads (re=1, io_sel=1) SHALL register rdata and pulse rvalid high for exactly one cycle on the next edge. An unmapped read SHALL return 0 with rvalid=1.
REQ-013 When re=0 or io_sel=0, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-014 Simultaneous we and re to the same address SHALL return the old value.
REQ-015 CYC SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0.
REQ-016 A read of CYC SHALL return the value present at the sampling edge.

Reset
REQ-017 While reset=1, the following SHALL be 0 on the next edge: OUT, STAT, MASK, CYC, all synchronizer and previous-value flops, rdata, rvalid, irq.
REQ-018 The edge after reset deasserts SHALL NOT set any STAT bit, because the previous-value register SHALL load the synchronized value during reset.
REQ-019 Reset asserted mid-access SHALL abort the access: no register update and no rvalid.

Structure
REQ-020 Address offsets (0x80, 0xC0, 0xF0, 0xF4, 0xF8) and parameter limits SHALL live in a shared package, sc_io_pkg.
REQ-021 The per-lane synchronizer, previous-value register and change detector SHALL be one sub-module, sc_io_sync_lane (parameter PORT_W), instantiated NUM_IN times.

Verification
REQ-022 Write 0xDEADBEEF to 0x84 (NUM_OUT=2):
- out_ports[63:32]=0xDEADBEEF one cycle later.
- A read of 0x84 returns it with one rvalid pulse.
REQ-023 Drive in_ports lane1 from 0 to 0x5 with MASK=0x2:
- STAT=0x2 and irq=1 three edges later.
- IN[1] reads 0x5.
REQ-024 Write 0x2 to 0xF0 in the same cycle lane1 changes again:
- STAT[1] stays 1.
- A later W1C with no change clears STAT and irq.
REQ-025 Read 0xA0 (unmapped); write 0xC0 (read-only):
- Read returns 0 with rvalid=1.
- IN[0] unchanged.
REQ-026 Preload the counter path by running 2^32 cycles (or force CYC=0xFFFFFFFF in the bench):
- Next read returns 0 after wrap.
REQ-027 Assert reset for one cycle while OUT[0]=0x1234 and STAT=0x3:
- All outputs 0 next cycle.
- No STAT set on the first post-reset edge with static inputs.

Source files
------------

// File: rtl/sc_io_pkg.sv
// Shared address map, parameter limits and register decode for the memory-mapped I/O ports.
package sc_io_pkg;

    localparam int unsigned MAX_PORTS  = 8;
    localparam int unsigned MAX_PORT_W = 32;

    localparam logic [7:0] OUT_BASE  = 8'h80;
    localparam logic [7:0] IN_BASE   = 8'hC0;
    localparam logic [7:0] STAT_ADDR = 8'hF0;
    localparam logic [7:0] MASK_ADDR = 8'hF4;
    localparam logic [7:0] CYC_ADDR  = 8'hF8;

    typedef enum logic [2:0] {RegNone, RegOut, RegIn, RegStat, RegMask, RegCyc} reg_kind_e;

    typedef struct packed {
        reg_kind_e  kind;
        logic [2:0] idx;
    } reg_sel_t;

    // Byte offset within the I/O page; addr[1:0] never affects the decode.
    function automatic reg_sel_t decode_addr(input logic [7:0] a, input int unsigned n_out,
                                             input int unsigned n_in);
        reg_sel_t   sel;
        logic [7:0] word;
        word     = {a[7:2], 2'b00};
        sel.idx  = a[4:2];
        sel.kind = RegNone;
        if (word[7:5] == OUT_BASE[7:5] && 32'(sel.idx) < n_out) begin
            sel.kind = RegOut;
        end else if (word[7:5] == IN_BASE[7:5] && 32'(sel.idx) < n_in) begin
            sel.kind = RegIn;
        end else if (word == STAT_ADDR) begin
            sel.kind = RegStat;
        end else if (word == MASK_ADDR) begin
            sel.kind = RegMask;
        end else if (word == CYC_ADDR) begin
            sel.kind = RegCyc;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sc_io_ports_if.sv
// CPU-side load/store bus of the I/O port block.
interface sc_io_ports_if;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        io_sel;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (output addr, wdata, we, re, input io_sel, rdata, rvalid);
    modport slave  (input addr, wdata, we, re, output io_sel, rdata, rvalid);

endinterface

// File: rtl/sc_io_sync_lane.sv
// One input lane: two-flop synchronizer, previous-value register and change detector.
module sc_io_sync_lane #(
    parameter int unsigned PORT_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PORT_W-1:0] lane_i,
    output logic [PORT_W-1:0] sync_o,
    output logic              changed_o
);

    logic [PORT_W-1:0] meta_q;
    logic [PORT_W-1:0] sync_q;
    logic [PORT_W-1:0] prev_q;

    // prev_q tracks sync_q through reset so the first post-reset edge sees no change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= lane_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o    = sync_q;
    assign changed_o = |(sync_q ^ prev_q);

endmodule

// File: rtl/sc_io_ports.sv
// Memory-mapped output/input ports with change-detect interrupt and free-running cycle counter.
module sc_io_ports
    import sc_io_pkg::*;
#(
    parameter int unsigned NUM_OUT = 2,
    parameter int unsigned NUM_IN  = 2,
    parameter int unsigned PORT_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    sc_io_ports_if.slave              bus,
    output logic [NUM_OUT*PORT_W-1:0] out_ports,
    input  logic [NUM_IN*PORT_W-1:0]  in_ports,
    output logic                      irq
);

    reg_sel_t          sel;
    logic              wr_en;
    logic              rd_en;
    logic [PORT_W-1:0] out_q [NUM_OUT];
    logic [PORT_W-1:0] out_d [NUM_OUT];
    logic [PORT_W-1:0] in_sync [NUM_IN];
    logic [NUM_IN-1:0] changed;
    logic [NUM_IN-1:0] stat_q;
    logic [NUM_IN-1:0] stat_d;
    logic [NUM_IN-1:0] mask_q;
    logic [NUM_IN-1:0] mask_d;
    logic [NUM_IN-1:0] w1c;
    logic [31:0]       cyc_q;
    logic [31:0]       rdata_q;
    logic [31:0]       rd_val;
    logic              rvalid_q;
    logic              irq_q;
    logic              unused_bits;

    assign bus.io_sel = bus.addr[7];
    assign sel        = decode_addr(bus.addr[7:0], NUM_OUT, NUM_IN);
    assign wr_en      = bus.we & bus.addr[7];
    assign rd_en      = bus.re & bus.addr[7];
    assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.wdata};

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        sc_io_sync_lane #(
            .PORT_W(PORT_W)
        ) u_lane (
            .clk_i    (clock),
            .rst_i    (reset),
            .lane_i   (in_ports[k*PORT_W +: PORT_W]),
            .sync_o   (in_sync[k]),
            .changed_o(changed[k])
        );
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign out_ports[k*PORT_W +: PORT_W] = out_q[k];
    end

    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        w1c    = '0;
        if (wr_en) begin
            case (sel.kind)
                RegOut: begin
                    for (int k = 0; k < NUM_OUT; k++) begin
                        if (sel.idx == 3'(k)) out_d[k] = bus.wdata[PORT_W-1:0];
                    end
                end
                RegStat: w1c    = bus.wdata[NUM_IN-1:0];
                RegMask: mask_d = bus.wdata[NUM_IN-1:0];
                default: ;
            endcase
        end
        // A change arriving with a W1C on the same bit keeps the bit set.
        stat_d = (stat_q & ~w1c) | changed;
    end

    always_comb begin
        rd_val = '0;
        case (sel.kind)
            RegOut: begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (sel.idx == 3'(k)) rd_val = 32'(out_q[k]);
                end
            end
            RegIn: begin
                for (int k = 0; k < NUM_IN; k++) begin
                    if (sel.idx == 3'(k)) rd_val = 32'(in_sync[k]);
                end
            end
            RegStat: rd_val = 32'(stat_q);
            RegMask: rd_val = 32'(mask_q);
            RegCyc:  rd_val = cyc_q;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q    <= '{default: '0};
            stat_q   <= '0;
            mask_q   <= '0;
            cyc_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            stat_q   <= stat_d;
            mask_q   <= mask_d;
            cyc_q    <= cyc_q + 32'd1;
            rvalid_q <= rd_en;
            irq_q    <= |(stat_d & mask_d);
            if (rd_en) rdata_q <= rd_val;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign irq        = irq_q;

endmodule
